sc_bitstream_gen: RTL



---
 rtl/sc_bitstream_gen.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sc_bitstream_gen.sv
// -----------------------------------------------------------------------------
// sc_bitstream_gen
//
// Binary-to-stochastic encoder. A start request latches a binary magnitude
// v (0..N, larger values saturate to N). The block then emits an N-bit unipolar
// stochastic frame containing v ones. The frame is sent serially, one bit per
// clock, and is also assembled into an N-bit parallel word, so a popcount of
// the word gives back v.
//
// Comparator reference:
//   default           : rev(cnt), the K-bit bit-reversal of the frame counter.
//                       This gives an exact ones count.
//   SNG_LFSR_EN set   : a K-bit maximal-length Fibonacci LFSR that free-runs
//                       across frames. The ones count is approximate.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   encode request, sampled only while idle
//   value      in   [K:0]   binary magnitude 0..N (saturates above N)
//   busy       out  frame in progress
//   bit_out    out  current serial stream bit
//   bit_valid  out  bit_out is a valid stream bit this cycle
//   bit_idx    out  [K-1:0] index of bit_out within the frame
//   word_out   out  [N-1:0] last complete frame, bit i = stream bit i
//   word_valid out  one-cycle pulse when word_out has just been updated
// -----------------------------------------------------------------------------
module sc_bitstream_gen #(
  parameter int unsigned K         = 3,
  parameter int unsigned LFSR_SEED = 1,
  localparam int unsigned N        = 2 ** K
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [K:0]     value,
  output logic           busy,
  output logic           bit_out,
  output logic           bit_valid,
  output logic [K-1:0]   bit_idx,
  output logic [N-1:0]   word_out,
  output logic           word_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // N expressed on the K+1 bit value bus: a one in the top bit only.
  localparam logic [K:0]   N_VAL    = {1'b1, {K{1'b0}}};
  localparam logic [K-1:0] CNT_LAST = {K{1'b1}};

  // Reject unsupported stream lengths and an all-zero seed (the all-zero
  // state locks an XOR LFSR) at elaboration time.
  generate
    if ((K < 32'd2) || (K > 32'd8)) begin : g_bad_k
      $error("sc_bitstream_gen: K must be in 2..8");
    end
    if ((LFSR_SEED & (N - 32'd1)) == 32'd0) begin : g_bad_seed
      $error("sc_bitstream_gen: LFSR_SEED must be nonzero in its low K bits");
    end
  endgenerate

  // K-bit bit reversal. Over cnt = 0..N-1 this is a permutation of 0..N-1, so
  // the comparison val > rev(cnt) is true for exactly val of the N bits.
  function automatic logic [K-1:0] bit_rev(input logic [K-1:0] x);
    logic [K-1:0] r;
    r = '0;
    for (int i = 0; i < int'(K); i++) begin
      r[i] = x[int'(K) - 1 - i];
    end
    return r;
  endfunction

  state_t         state_q,      state_d;
  logic [K:0]     val_q,        val_d;
  logic [K-1:0]   cnt_q,        cnt_d;
  logic [N-1:0]   word_sr_q,    word_sr_d;
  logic           busy_q,       busy_d;
  logic           bit_out_q,    bit_out_d;
  logic           bit_valid_q,  bit_valid_d;
  logic [K-1:0]   bit_idx_q,    bit_idx_d;
  logic [N-1:0]   word_out_q,   word_out_d;
  logic           word_valid_q, word_valid_d;

  logic [K-1:0]   ref_s;
  logic           run_bit_s;

`ifdef SNG_LFSR_EN
  // Feedback tap masks (bit positions, 0-based) of maximal-length polynomials
  // for K = 2..8.
  function automatic logic [7:0] tap_mask(input int unsigned k);
    logic [7:0] m;
    case (k)
      32'd2:   m = 8'h03;
      32'd3:   m = 8'h06;
      32'd4:   m = 8'h0C;
      32'd5:   m = 8'h14;
      32'd6:   m = 8'h30;
      32'd7:   m = 8'h60;
      32'd8:   m = 8'hB8;
      default: m = 8'h03;
    endcase
    return m;
  endfunction

  localparam logic [7:0]   TAPS   = tap_mask(K);
  localparam logic [K-1:0] SEED_K = K'(LFSR_SEED);

  // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [K-1:0] lfsr_step(input logic [K-1:0] s);
    logic fb;
    fb = ^(s & TAPS[K-1:0]);
    return {s[K-2:0], fb};
  endfunction

  logic [K-1:0] lfsr_q, lfsr_d;

  // The LFSR never holds zero, so value=0 gives all zeros and value=N all ones.
  assign ref_s = lfsr_q;
`else
  assign ref_s = bit_rev(cnt_q);
`endif

  assign run_bit_s = ({1'b0, ref_s} < val_q);

  // Next-state and next-output logic for the IDLE/RUN/DONE frame sequencer.
  always_comb begin
    state_d      = state_q;
    val_d        = val_q;
    cnt_d        = cnt_q;
    word_sr_d    = word_sr_q;
    busy_d       = busy_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = bit_valid_q;
    bit_idx_d    = bit_idx_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
`ifdef SNG_LFSR_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        if (start) begin
          val_d     = (value > N_VAL) ? N_VAL : value;
          cnt_d     = '0;
          word_sr_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      RUN: begin
        bit_out_d          = run_bit_s;
        bit_valid_d        = 1'b1;
        bit_idx_d          = cnt_q;
        word_sr_d[cnt_q]   = run_bit_s;
        cnt_d              = cnt_q + {{(K-1){1'b0}}, 1'b1};
`ifdef SNG_LFSR_EN
        lfsr_d             = lfsr_step(lfsr_q);
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // word_sr_q already holds bit N-1, written on the last RUN edge.
        word_out_d   = word_sr_q;
        word_valid_d = 1'b1;
        bit_out_d    = 1'b0;
        bit_valid_d  = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      val_q        <= '0;
      cnt_q        <= '0;
      word_sr_q    <= '0;
      busy_q       <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_idx_q    <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
`ifdef SNG_LFSR_EN
      lfsr_q       <= SEED_K;
`endif
    end else begin
      state_q      <= state_d;
      val_q        <= val_d;
      cnt_q        <= cnt_d;
      word_sr_q    <= word_sr_d;
      busy_q       <= busy_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_idx_q    <= bit_idx_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
`ifdef SNG_LFSR_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign bit_idx    = bit_idx_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

endmodule
